// File: rtl/mdu_iterative_pkg.sv
// rtl/mdu_iterative_pkg.sv - op codes, FSM states and op decode helpers for the multiply/divide unit
package mdu_iterative_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  // Even op codes are the signed variants
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// rtl/mdu_iterative_if.sv - execute-stage bundle between the pipeline and the multiply/divide unit
interface mdu_iterative_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wd,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_iterative_step.sv
// rtl/mdu_iterative_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module mdu_iterative_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Multiply: {acc_hi,acc_lo} is the product shifting right with the multiplier draining out of acc_lo.
  // Divide: {acc_hi,acc_lo} is {remainder,dividend/quotient} shifting left; the remainder stays below
  // the divisor, so the trial subtract of the shifted remainder never needs more than one extra bit.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd};
    nxt_hi  = sum[WIDTH:1];
    nxt_lo  = {sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        nxt_hi = diff[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - fixed-latency iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mdu_iterative
  import mdu_iterative_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mdu_iterative_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdu_state_e       state;
  mdu_state_e       state_nxt;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic             sign_a;
  logic             sign_b;
  logic             div0;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic             in_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign in_signed = op_is_signed(bus.op);
  assign a_mag     = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  assign bus.busy  = (state != ST_IDLE);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  mdu_iterative_step #(.WIDTH(WIDTH)) u_step (
    .is_div (op_is_div(op_q)),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .opnd   (opnd_b),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: one launch edge, WIDTH iteration edges, one sign-fix edge
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sign correction on the magnitude result; divide by zero returns the raw dividend and all-ones
  always_comb begin
    prod   = {acc_hi, acc_lo};
    quot   = acc_lo;
    rem    = acc_hi;
    if (op_q == OP_MULT && (sign_a ^ sign_b)) prod = -prod;
    if (op_q == OP_DIV) begin
      if (sign_a ^ sign_b) quot = -quot;
      if (sign_a)          rem  = -rem;
    end
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_is_div(op_q)) begin
      res_hi = div0 ? a_raw : rem;
      res_lo = div0 ? {WIDTH{1'b1}} : quot;
    end
  end

  // Datapath: launch captures magnitudes, RUN iterates, FIX commits to hi/lo; MTHI/MTLO only in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      div0   <= 1'b0;
      a_raw  <= '0;
      opnd_b <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.hi_we) hi_q <= bus.wd;
          if (bus.lo_we) lo_q <= bus.wd;
          if (bus.start) begin
            op_q   <= bus.op;
            sign_a <= in_signed & bus.a[WIDTH-1];
            sign_b <= in_signed & bus.b[WIDTH-1];
            div0   <= (bus.b == '0);
            a_raw  <= bus.a;
            opnd_b <= b_mag;
            acc_hi <= '0;
            acc_lo <= a_mag;
            cnt    <= '0;
          end
        end
        ST_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CW'(1);
        end
        ST_FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - scoreboard bench for the iterative multiply/divide unit
module tb_mdu_iterative;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   edges = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_iterative_if #(.WIDTH(32)) bus ();

  mdu_iterative #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: whole-result arithmetic on 64-bit integers
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned up;
    logic [31:0]     q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin p = sa * sb; return p; end
      2'd1: begin up = {32'b0, a} * {32'b0, b}; return up; end
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation, on time
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at edge %0d", edges);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_hi", 64'(bus.hi), 64'(e.hi));
        chk("result_lo", 64'(bus.lo), 64'(e.lo));
        chk("latency_edge", 64'(edges), 64'(e.edge_no));
      end
    end
  end

  // Launch an op from IDLE (or the done cycle); called #1 after a posedge
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic hwe, input logic lwe, input logic [31:0] wd);
    exp_t        e;
    logic [63:0] r;
    r = ref_result(op, a, b);
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.edge_no = edges + 1 + 33;
    exp_q.push_back(e);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    bus.hi_we = hwe;  bus.lo_we = lwe; bus.wd = wd;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    if (hwe) chk("mthi_with_start", 64'(bus.hi), 64'(wd));
    if (lwe) chk("mtlo_with_start", 64'(bus.lo), 64'(wd));
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) return;
      @(posedge clk); #1;
    end
    chk("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.done) return;
    end
    chk("done_timeout", 64'(bus.done), 64'd1);
  endtask

  initial begin
    logic [31:0] old_hi, old_lo, ra, rb, rw;
    logic [1:0]  rop;
    int          sel;

    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // MULTU max*max, then DIVU 100/7 launched in its done cycle
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    wait_done();
    issue(2'd3, 32'd100, 32'd7, 1'b0, 1'b0, '0);
    wait_done();
    bus.lo_we = 1'b1; bus.wd = 32'd5;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    chk("mtlo_idle_lo", 64'(bus.lo), 64'd5);
    chk("mtlo_idle_hi", 64'(bus.hi), 64'(m_hi));
    m_lo = 32'd5;

    // Signed multiply/divide, divide by zero and the signed overflow case
    issue(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, '0);          wait_done();
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0);          wait_done();
    issue(2'd3, 32'd7, 32'd2, 1'b0, 1'b0, '0);                  wait_done();
    issue(2'd3, 32'h0000_1234, 32'd0, 1'b0, 1'b0, '0);          wait_done();
    issue(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0, '0);          wait_done();
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);  wait_done();

    // start and MTHI while busy are both ignored
    old_hi = m_hi;
    issue(2'd1, 32'd6, 32'd7, 1'b0, 1'b0, '0);
    repeat (3) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd99; bus.b = 32'd9;
    bus.hi_we = 1'b1; bus.wd = 32'h0000_AAAA;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0;
    chk("mthi_busy_ignored", 64'(bus.hi), 64'(old_hi));
    wait_done();

    // Reset mid-operation discards the op: no done pulse follows
    bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd11; bus.b = 32'd13;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_lo", 64'(bus.lo), 64'd0);
    m_hi = '0; m_lo = '0;
    repeat (40) begin @(posedge clk); #1; end

    // Randomized back-to-back ops, with occasional MTHI/MTLO alongside start
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 255);
      rw = $urandom;
      wait_idle();
      issue(rop, ra, rb, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), rw);
    end
    wait_idle();
    repeat (3) begin @(posedge clk); #1; end
    chk("pending_results", 64'(exp_q.size()), 64'd0);
    old_lo = m_lo;
    chk("final_lo_model", 64'(bus.lo), 64'(old_lo));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
